pong_game_ctrl: RTL and testbench
=================================

// Module: pong_game_ctrl
// PURPOSE
//  Game-level sequencer for the bouncing-ball/paddle datapath. Decides when the ball is parked,
//  served, moving or frozen. Counts paddle hits into a 2-digit BCD score, counts down lives and
//  raises the per-frame ball step as the rally grows. Sits between the VGA timing (frame tick)
//  and the ball/paddle logic; drives the ball load/enable controls and the score overlay.
// PARAMETERS
//  LIVES          3    lives at game start (1..7)
//  SERVE_FRAMES   60   frames spent parked in SERVE before the ball is released (1..255)
//  MISS_FRAMES    90   frames frozen after a miss (1..255)
//  MISS_Y         464  ball_y value (top edge of ball) at or beyond which the ball is lost
//  SPEEDUP_HITS   5    paddle hits per step increase
//  MAX_STEP       3    max pixels per frame (1..3)
//  SERVE_X        312  ball reload X;  SERVE_Y 64  ball reload Y
// PORTS
//  clk           in   1   pixel clock
//  reset         in   1   synchronous, active-high
//  frame_tick    in   1   1-cycle pulse, once per frame (vertical blank)
//  start_btn     in   1   level, already synchronised; only its rising edge is used
//  paddle_hit    in   1   1-cycle pulse when ball collides with paddle
//  ball_y        in   9   current ball top Y
//  ball_load     out  1   1-cycle pulse: ball loads ball_load_x/y, dir_x = serve_dir
//  ball_load_x   out  10  constant SERVE_X;  ball_load_y  out 9  constant SERVE_Y
//  serve_dir     out  1   X direction applied on load (0 = +X, 1 = -X)
//  ball_run      out  1   ball position updates only while 1
//  ball_step     out  2   pixels per frame while running
//  score_bcd     out  8   {tens, ones} BCD
//  lives         out  3   lives remaining
//  game_state    out  3   encoded FSM state (for overlay text)
// BEHAVIOUR
//  Reset: state IDLE, ball_load 0, ball_run 0, ball_step 1, score 00, lives LIVES, serve_dir 0,
//   frame counter 0, hit counter 0, start edge detector cleared. All outputs registered.
//  IDLE: ball parked. start rise -> SERVE, ball_load pulse the following cycle, score/lives
//   reset, step 1.
//  SERVE: counts frame_ticks; at SERVE_FRAMES-th tick -> PLAY, ball_run=1 next cycle.
//  PLAY: paddle_hit -> score +1 (BCD, saturates at 99), hit counter +1; on reaching
//   SPEEDUP_HITS hit counter clears and step increments, saturating at MAX_STEP.
//   On frame_tick with ball_y >= MISS_Y: -> MISS, ball_run=0, lives-1.
//   paddle_hit and miss in the same cycle: hit is scored, the miss is ignored for that frame.
//  MISS: counts MISS_FRAMES ticks, then: lives==0 -> OVER; else -> SERVE with ball_load pulse,
//   serve_dir toggled, step back to 1, hit counter cleared (score retained).
//  OVER: ball_run 0, score frozen; start rise -> IDLE (needs a second rise to serve).
//  Frame counter clears on every state entry; frame_tick in the entry cycle counts as tick 1.
//  start_btn held high across reset does not count as a rise.
//  paddle_hit outside PLAY is ignored.
//  reset mid-game: next cycle is IDLE with all reset values; no ball_load pulse.
//  Latency: every input event is reflected on outputs exactly 1 clk later.
// STRUCTURE
//  pong_pkg: state enum (IDLE=0, SERVE=1, PLAY=2, MISS=3, OVER=4), H_RES 640, V_RES 480,
//   BALL_SIZE 16, shared by ball, paddle and overlay blocks.
//  Sub-module: bcd_cnt2 (2-digit BCD incrementer with clear and saturation at 99).
//  The frame/hit counters and edge detector stay inline.
// TESTING
//  reset, start rise, 60 ticks -> ball_load 1 cycle after the rise, ball_run=1 after the 60th tick.
//  PLAY, 12 paddle_hit -> score 0x12, step 1->2 (hit 5)->3 (hit 10), stays 3.
//  ball_y=464 on tick, lives 3 -> MISS, lives 2; after 90 ticks SERVE, serve_dir toggles, step 1.
//  3 misses -> OVER, lives 0; start rise -> IDLE; second rise -> score 00, lives 3.
//  paddle_hit with a miss tick in the same cycle -> score+1, stays PLAY, lives unchanged.
//  99 hits then 1 more -> score 0x99 held; reset mid-PLAY -> IDLE, ball_run 0, score 00.

Source files
------------

// File: rtl/pong_pkg.sv
// pong_pkg
//   Shared definitions for the pong datapath blocks (ball, paddle, overlay,
//   game controller): game FSM state encoding, screen geometry and the
//   saturating 2-digit BCD increment used by the score counter.
package pong_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SERVE = 3'd1,
      ST_PLAY  = 3'd2,
      ST_MISS  = 3'd3,
      ST_OVER  = 3'd4
   } game_state_t;

   localparam int unsigned H_RES     = 640;
   localparam int unsigned V_RES     = 480;
   localparam int unsigned BALL_SIZE = 16;

   // {tens, ones} + 1, holding at 99
   function automatic logic [7:0] bcd_inc_sat(input logic [7:0] v);
      if (v == 8'h99)
         return v;
      if (v[3:0] == 4'd9)
         return {v[7:4] + 4'd1, 4'd0};
      return {v[7:4], v[3:0] + 4'd1};
   endfunction

endpackage

// File: rtl/pong_game_ctrl_if.sv
// pong_game_ctrl_if
//   Ball control bundle between the game controller (master) and the
//   ball/paddle datapath (slave).
//   ball_load    ctrl->ball  1-cycle pulse: load ball_load_x/y, dir_x = serve_dir
//   ball_load_x  ctrl->ball  reload X
//   ball_load_y  ctrl->ball  reload Y
//   serve_dir    ctrl->ball  X direction applied on load (0 = +X, 1 = -X)
//   ball_run     ctrl->ball  ball position updates only while 1
//   ball_step    ctrl->ball  pixels per frame while running
//   paddle_hit   ball->ctrl  1-cycle pulse on ball/paddle collision
//   ball_y       ball->ctrl  current ball top Y
interface pong_game_ctrl_if;

   logic       ball_load;
   logic [9:0] ball_load_x;
   logic [8:0] ball_load_y;
   logic       serve_dir;
   logic       ball_run;
   logic [1:0] ball_step;
   logic       paddle_hit;
   logic [8:0] ball_y;

   modport master (
      output ball_load, ball_load_x, ball_load_y, serve_dir, ball_run, ball_step,
      input  paddle_hit, ball_y
   );

   modport slave (
      input  ball_load, ball_load_x, ball_load_y, serve_dir, ball_run, ball_step,
      output paddle_hit, ball_y
   );

endinterface

// File: rtl/pong_game_ctrl_bcd_cnt2.sv
// bcd_cnt2
//   Two-digit BCD counter with synchronous clear and saturation at 99.
//   clk    in   clock
//   reset  in   synchronous, active-high
//   clr    in   synchronous clear to 00
//   inc    in   increment by one (held at 99)
//   bcd    out  {tens, ones}, registered
module bcd_cnt2
   import pong_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       clr,
   input  logic       inc,
   output logic [7:0] bcd
);

   always_ff @(posedge clk) begin
      if (reset || clr)
         bcd <= '0;
      else if (inc)
         bcd <= bcd_inc_sat(bcd);
   end

endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl
//   Game-level sequencer: parks, serves, runs and freezes the ball, keeps the
//   BCD score, counts down lives and raises the ball step as the rally grows.
//   clk         in   pixel clock
//   reset       in   synchronous, active-high
//   frame_tick  in   1-cycle pulse once per frame
//   start_btn   in   synchronised level; only its rising edge is used
//   ball        ball control bundle (master side)
//   score_bcd   out  {tens, ones} BCD score
//   lives       out  lives remaining
//   game_state  out  encoded FSM state for the overlay
module pong_game_ctrl
   import pong_pkg::*;
#(
   parameter int unsigned LIVES        = 3,
   parameter int unsigned SERVE_FRAMES = 60,
   parameter int unsigned MISS_FRAMES  = 90,
   parameter int unsigned MISS_Y       = 464,
   parameter int unsigned SPEEDUP_HITS = 5,
   parameter int unsigned MAX_STEP     = 3,
   parameter int unsigned SERVE_X      = 312,
   parameter int unsigned SERVE_Y      = 64
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    frame_tick,
   input  logic                    start_btn,
   pong_game_ctrl_if.master        ball,
   output logic [7:0]              score_bcd,
   output logic [2:0]              lives,
   output logic [2:0]              game_state
);

   localparam logic [7:0] SERVE_LAST   = 8'(SERVE_FRAMES - 1);
   localparam logic [7:0] MISS_LAST    = 8'(MISS_FRAMES - 1);
   localparam logic [7:0] SPEEDUP_LAST = 8'(SPEEDUP_HITS - 1);
   localparam logic [8:0] MISS_Y9      = 9'(MISS_Y);
   localparam logic [1:0] MAX_STEP2    = 2'(MAX_STEP);
   localparam logic [2:0] LIVES3       = 3'(LIVES);

   game_state_t state;
   logic        startPrev;
   logic [7:0]  frameCnt;
   logic [7:0]  hitCnt;
   logic        startRise;
   logic        scoreClr;
   logic        scoreInc;

   assign startRise = start_btn & ~startPrev;
   assign scoreClr  = (state == ST_IDLE) && startRise;
   assign scoreInc  = (state == ST_PLAY) && ball.paddle_hit;

   assign game_state       = state;
   assign ball.ball_load_x = 10'(SERVE_X);
   assign ball.ball_load_y = 9'(SERVE_Y);

   bcd_cnt2 u_score (
      .clk   (clk),
      .reset (reset),
      .clr   (scoreClr),
      .inc   (scoreInc),
      .bcd   (score_bcd)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= ST_IDLE;
         // sample the button so a level held through reset is not a rise
         startPrev      <= start_btn;
         frameCnt       <= '0;
         hitCnt         <= '0;
         ball.ball_load <= 1'b0;
         ball.ball_run  <= 1'b0;
         ball.ball_step <= 2'd1;
         ball.serve_dir <= 1'b0;
         lives          <= LIVES3;
      end else begin
         startPrev      <= start_btn;
         ball.ball_load <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (startRise) begin
                  state          <= ST_SERVE;
                  frameCnt       <= '0;
                  hitCnt         <= '0;
                  ball.ball_load <= 1'b1;
                  ball.ball_step <= 2'd1;
                  lives          <= LIVES3;
               end
            end
            ST_SERVE: begin
               if (frame_tick) begin
                  if (frameCnt == SERVE_LAST) begin
                     state         <= ST_PLAY;
                     frameCnt      <= '0;
                     ball.ball_run <= 1'b1;
                  end else begin
                     frameCnt <= frameCnt + 8'd1;
                  end
               end
            end
            ST_PLAY: begin
               // a hit in the same cycle masks that frame's miss test
               if (ball.paddle_hit) begin
                  if (hitCnt == SPEEDUP_LAST) begin
                     hitCnt <= '0;
                     if (ball.ball_step < MAX_STEP2)
                        ball.ball_step <= ball.ball_step + 2'd1;
                  end else begin
                     hitCnt <= hitCnt + 8'd1;
                  end
               end else if (frame_tick && (ball.ball_y >= MISS_Y9)) begin
                  state         <= ST_MISS;
                  frameCnt      <= '0;
                  ball.ball_run <= 1'b0;
                  lives         <= lives - 3'd1;
               end
            end
            ST_MISS: begin
               if (frame_tick) begin
                  if (frameCnt == MISS_LAST) begin
                     frameCnt <= '0;
                     if (lives == 3'd0) begin
                        state <= ST_OVER;
                     end else begin
                        state          <= ST_SERVE;
                        ball.ball_load <= 1'b1;
                        ball.serve_dir <= ~ball.serve_dir;
                        ball.ball_step <= 2'd1;
                        hitCnt         <= '0;
                     end
                  end else begin
                     frameCnt <= frameCnt + 8'd1;
                  end
               end
            end
            ST_OVER: begin
               if (startRise) begin
                  state    <= ST_IDLE;
                  frameCnt <= '0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl
//   Scenario bench for pong_game_ctrl: expected score/step/flag values are
//   queued as stimulus is applied and popped once the controller responds.
module tb_pong_game_ctrl;
   import pong_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       frame_tick;
   logic       start_btn;
   logic [7:0] score_bcd;
   logic [2:0] lives;
   logic [2:0] game_state;

   pong_game_ctrl_if bif();

   pong_game_ctrl #(
      .LIVES        (3),
      .SERVE_FRAMES (60),
      .MISS_FRAMES  (90),
      .MISS_Y       (464),
      .SPEEDUP_HITS (5),
      .MAX_STEP     (3),
      .SERVE_X      (312),
      .SERVE_Y      (64)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .frame_tick (frame_tick),
      .start_btn  (start_btn),
      .ball       (bif),
      .score_bcd  (score_bcd),
      .lives      (lives),
      .game_state (game_state)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] score;
      logic [1:0] step;
   } hit_exp_t;

   hit_exp_t hitQ[$];
   logic     flagQ[$];

   function automatic logic [7:0] to_bcd(input int n);
      return 8'(((n / 10) << 4) | (n % 10));
   endfunction

   // advance one clock; outputs are settled 1 ns after the edge
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic run_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         frame_tick = 1'b1;
         cyc();
         frame_tick = 1'b0;
         cyc();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start_btn = 1'b0; frame_tick = 1'b0;
      bif.paddle_hit = 1'b0; bif.ball_y = 9'd100;
      cyc(); cyc();
      checks++; if (game_state !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d want %0d", game_state, ST_IDLE); end
      checks++; if (bif.ball_load !== 1'b0) begin errors++; $display("FAIL reset_load got %0b want 0", bif.ball_load); end
      checks++; if (bif.ball_run !== 1'b0) begin errors++; $display("FAIL reset_run got %0b want 0", bif.ball_run); end
      checks++; if (bif.ball_step !== 2'd1) begin errors++; $display("FAIL reset_step got %0d want 1", bif.ball_step); end
      checks++; if (score_bcd !== 8'h00) begin errors++; $display("FAIL reset_score got %0h want 00", score_bcd); end
      checks++; if (lives !== 3'd3) begin errors++; $display("FAIL reset_lives got %0d want 3", lives); end
      checks++; if (bif.serve_dir !== 1'b0) begin errors++; $display("FAIL reset_dir got %0b want 0", bif.serve_dir); end
      checks++; if (bif.ball_load_x !== 10'd312 || bif.ball_load_y !== 9'd64) begin errors++; $display("FAIL reset_loadxy got %0d,%0d want 312,64", bif.ball_load_x, bif.ball_load_y); end
      reset = 1'b0;
      cyc();
   endtask

   task automatic test_serve();
      logic fe;
      start_btn = 1'b1;
      cyc();
      checks++; if (bif.ball_load !== 1'b1) begin errors++; $display("FAIL serve_load got %0b want 1", bif.ball_load); end
      checks++; if (game_state !== ST_SERVE) begin errors++; $display("FAIL serve_state got %0d want %0d", game_state, ST_SERVE); end
      cyc();
      checks++; if (bif.ball_load !== 1'b0) begin errors++; $display("FAIL serve_load_pulse got %0b want 0", bif.ball_load); end
      start_btn = 1'b0;
      for (int i = 1; i <= 60; i++) begin
         flagQ.push_back(i == 60);
         frame_tick = 1'b1;
         cyc();
         frame_tick = 1'b0;
         fe = flagQ.pop_front();
         checks++; if (bif.ball_run !== fe) begin errors++; $display("FAIL serve_run tick %0d got %0b want %0b", i, bif.ball_run, fe); end
         cyc();
      end
      checks++; if (game_state !== ST_PLAY) begin errors++; $display("FAIL serve_play got %0d want %0d", game_state, ST_PLAY); end
   endtask

   task automatic test_hits();
      hit_exp_t he;
      for (int i = 1; i <= 16; i++) begin
         he.score = to_bcd(i);
         he.step  = (i >= 10) ? 2'd3 : (i >= 5) ? 2'd2 : 2'd1;
         hitQ.push_back(he);
         bif.paddle_hit = 1'b1;
         cyc();
         bif.paddle_hit = 1'b0;
         he = hitQ.pop_front();
         checks++; if (score_bcd !== he.score) begin errors++; $display("FAIL hits_score hit %0d got %0h want %0h", i, score_bcd, he.score); end
         checks++; if (bif.ball_step !== he.step) begin errors++; $display("FAIL hits_step hit %0d got %0d want %0d", i, bif.ball_step, he.step); end
         if (i[0]) cyc();
      end
   endtask

   task automatic test_hit_and_miss();
      bif.paddle_hit = 1'b1; frame_tick = 1'b1; bif.ball_y = 9'd464;
      cyc();
      bif.paddle_hit = 1'b0; frame_tick = 1'b0; bif.ball_y = 9'd100;
      checks++; if (score_bcd !== 8'h17) begin errors++; $display("FAIL same_score got %0h want 17", score_bcd); end
      checks++; if (game_state !== ST_PLAY || lives !== 3'd3) begin errors++; $display("FAIL same_state got %0d/%0d want %0d/3", game_state, lives, ST_PLAY); end
      cyc();
   endtask

   task automatic test_miss();
      logic fe;
      hit_exp_t he;
      frame_tick = 1'b1; bif.ball_y = 9'd463;
      cyc();
      frame_tick = 1'b0; bif.ball_y = 9'd100;
      checks++; if (game_state !== ST_PLAY) begin errors++; $display("FAIL miss_edge463 got %0d want %0d", game_state, ST_PLAY); end
      cyc();
      frame_tick = 1'b1; bif.ball_y = 9'd464;
      cyc();
      frame_tick = 1'b0; bif.ball_y = 9'd100;
      checks++; if (game_state !== ST_MISS) begin errors++; $display("FAIL miss_state got %0d want %0d", game_state, ST_MISS); end
      checks++; if (bif.ball_run !== 1'b0) begin errors++; $display("FAIL miss_run got %0b want 0", bif.ball_run); end
      checks++; if (lives !== 3'd2) begin errors++; $display("FAIL miss_lives got %0d want 2", lives); end
      cyc();
      bif.paddle_hit = 1'b1;
      cyc();
      bif.paddle_hit = 1'b0;
      checks++; if (score_bcd !== 8'h17) begin errors++; $display("FAIL miss_hit_ignored got %0h want 17", score_bcd); end
      for (int i = 1; i <= 90; i++) begin
         flagQ.push_back(i == 90);
         frame_tick = 1'b1;
         cyc();
         frame_tick = 1'b0;
         fe = flagQ.pop_front();
         checks++; if (bif.ball_load !== fe) begin errors++; $display("FAIL miss_reload tick %0d got %0b want %0b", i, bif.ball_load, fe); end
         cyc();
      end
      checks++; if (game_state !== ST_SERVE || bif.ball_load !== 1'b0) begin errors++; $display("FAIL miss_reserve got %0d/%0b want %0d/0", game_state, bif.ball_load, ST_SERVE); end
      checks++; if (bif.serve_dir !== 1'b1) begin errors++; $display("FAIL miss_dir got %0b want 1", bif.serve_dir); end
      checks++; if (bif.ball_step !== 2'd1) begin errors++; $display("FAIL miss_step got %0d want 1", bif.ball_step); end
      run_ticks(60);
      for (int i = 1; i <= 5; i++) begin
         he.score = to_bcd(17 + i);
         he.step  = (i == 5) ? 2'd2 : 2'd1;
         hitQ.push_back(he);
         bif.paddle_hit = 1'b1;
         cyc();
         bif.paddle_hit = 1'b0;
         he = hitQ.pop_front();
         checks++; if (score_bcd !== he.score || bif.ball_step !== he.step) begin errors++; $display("FAIL rally_hit %0d got %0h/%0d want %0h/%0d", i, score_bcd, bif.ball_step, he.score, he.step); end
      end
   endtask

   task automatic test_game_over();
      frame_tick = 1'b1; bif.ball_y = 9'd470;
      cyc();
      frame_tick = 1'b0; bif.ball_y = 9'd100;
      checks++; if (lives !== 3'd1) begin errors++; $display("FAIL over_lives1 got %0d want 1", lives); end
      run_ticks(90);
      checks++; if (game_state !== ST_SERVE || bif.serve_dir !== 1'b0) begin errors++; $display("FAIL over_serve2 got %0d/%0b want %0d/0", game_state, bif.serve_dir, ST_SERVE); end
      run_ticks(60);
      frame_tick = 1'b1; bif.ball_y = 9'd464;
      cyc();
      frame_tick = 1'b0; bif.ball_y = 9'd100;
      checks++; if (lives !== 3'd0 || game_state !== ST_MISS) begin errors++; $display("FAIL over_lives0 got %0d/%0d want 0/%0d", lives, game_state, ST_MISS); end
      run_ticks(90);
      checks++; if (game_state !== ST_OVER) begin errors++; $display("FAIL over_state got %0d want %0d", game_state, ST_OVER); end
      checks++; if (bif.ball_load !== 1'b0 || bif.ball_run !== 1'b0) begin errors++; $display("FAIL over_ball got %0b/%0b want 0/0", bif.ball_load, bif.ball_run); end
      bif.paddle_hit = 1'b1;
      cyc();
      bif.paddle_hit = 1'b0;
      checks++; if (score_bcd !== 8'h22) begin errors++; $display("FAIL over_score got %0h want 22", score_bcd); end
      start_btn = 1'b1;
      cyc();
      checks++; if (game_state !== ST_IDLE || bif.ball_load !== 1'b0) begin errors++; $display("FAIL over_idle got %0d/%0b want %0d/0", game_state, bif.ball_load, ST_IDLE); end
      start_btn = 1'b0;
      cyc();
      start_btn = 1'b1;
      cyc();
      start_btn = 1'b0;
      checks++; if (game_state !== ST_SERVE || bif.ball_load !== 1'b1) begin errors++; $display("FAIL over_restart got %0d/%0b want %0d/1", game_state, bif.ball_load, ST_SERVE); end
      checks++; if (score_bcd !== 8'h00 || lives !== 3'd3) begin errors++; $display("FAIL over_newgame got %0h/%0d want 00/3", score_bcd, lives); end
   endtask

   task automatic test_saturation();
      hit_exp_t he;
      run_ticks(60);
      for (int i = 1; i <= 100; i++) begin
         he.score = to_bcd((i > 99) ? 99 : i);
         he.step  = (i >= 10) ? 2'd3 : (i >= 5) ? 2'd2 : 2'd1;
         hitQ.push_back(he);
         bif.paddle_hit = 1'b1;
         cyc();
         bif.paddle_hit = 1'b0;
         he = hitQ.pop_front();
         checks++; if (score_bcd !== he.score || bif.ball_step !== he.step) begin errors++; $display("FAIL sat_hit %0d got %0h/%0d want %0h/%0d", i, score_bcd, bif.ball_step, he.score, he.step); end
      end
   endtask

   task automatic test_reset_mid();
      start_btn = 1'b1; reset = 1'b1;
      cyc();
      reset = 1'b0;
      checks++; if (game_state !== ST_IDLE || bif.ball_run !== 1'b0) begin errors++; $display("FAIL midrst_state got %0d/%0b want %0d/0", game_state, bif.ball_run, ST_IDLE); end
      checks++; if (score_bcd !== 8'h00 || lives !== 3'd3 || bif.ball_step !== 2'd1) begin errors++; $display("FAIL midrst_vals got %0h/%0d/%0d want 00/3/1", score_bcd, lives, bif.ball_step); end
      checks++; if (bif.ball_load !== 1'b0) begin errors++; $display("FAIL midrst_load got %0b want 0", bif.ball_load); end
      cyc(); cyc();
      checks++; if (game_state !== ST_IDLE || bif.ball_load !== 1'b0) begin errors++; $display("FAIL midrst_held got %0d/%0b want %0d/0", game_state, bif.ball_load, ST_IDLE); end
      start_btn = 1'b0;
      cyc();
      start_btn = 1'b1;
      cyc();
      start_btn = 1'b0;
      checks++; if (game_state !== ST_SERVE) begin errors++; $display("FAIL midrst_rise got %0d want %0d", game_state, ST_SERVE); end
   endtask

   initial begin
      test_reset();
      test_serve();
      test_hits();
      test_hit_and_miss();
      test_miss();
      test_game_over();
      test_saturation();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
